// File: rtl/mod_clk_pkg.sv
// Shared types and constants for the modulation clock config sequencer.
// Select field widths, FSM states and the power-on configuration.
package mod_clk_pkg;

  localparam int FREQ_W       = 3;
  localparam int PHASE_W      = 5;
  localparam int DUTY_W       = 4;
  localparam int SEL_W        = FREQ_W + PHASE_W + DUTY_W;
  localparam int NUM_FREQ_DEF = 3;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_GATE,
    ST_APPLY,
    ST_WAIT_LOCK,
    ST_SETTLE,
    ST_FAULT
  } state_e;

  typedef struct packed {
    logic [FREQ_W-1:0]  freq;
    logic [PHASE_W-1:0] phase;
    logic [DUTY_W-1:0]  duty;
  } sel_t;

  localparam sel_t SEL_RST = sel_t'(0);

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mod_clk_cfg_sequencer_sel_sync_debounce.sv
// Multi-bit synchroniser plus stability counter for the select bus.
// pulse_o fires once when a code has been steady for DEBOUNCE cycles.
module sel_sync_debounce #(
  parameter int W        = 12,
  parameter int STAGES   = 2,
  parameter int DEBOUNCE = 1024
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] code_o,
  output logic         pulse_o
);

  localparam int CW = $clog2(DEBOUNCE);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE - 1);

  logic [W-1:0]  sync_q [STAGES];
  logic [W-1:0]  cand_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          stab_q;
  logic          stable;
  logic [W-1:0]  synced;

  assign synced  = sync_q[STAGES-1];
  assign stable  = (cnt_q == CMAX);
  assign code_o  = cand_q;
  assign pulse_o = stable & ~stab_q;

  always_comb begin
    cnt_d = cnt_q;
    if (synced != cand_q)
      cnt_d = '0;
    else if (cnt_q != CMAX)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++)
        sync_q[i] <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
      stab_q <= 1'b0;
    end else begin
      sync_q[0] <= raw_i;
      for (int i = 1; i < STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      cand_q <= synced;
      cnt_q  <= cnt_d;
      stab_q <= stable;
    end
  end

endmodule

// File: rtl/mod_clk_cfg_sequencer.sv
// Glitch-free sequencing of freq/phase/duty select changes:
// gate clocks, drain, apply, wait for lock, settle, re-enable.
module mod_clk_cfg_sequencer
  import mod_clk_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int DRAIN_CYCLES    = 16,
  parameter int SETTLE_CYCLES   = 64,
  parameter int LOCK_TIMEOUT    = 65535,
  parameter int NUM_FREQ        = NUM_FREQ_DEF
) (
  input  logic               USER_CLOCK,
  input  logic               RESET,
  input  logic [FREQ_W-1:0]  FREQ_SEL_IN,
  input  logic [PHASE_W-1:0] PHASE_SEL_IN,
  input  logic [DUTY_W-1:0]  DUTY_SEL_IN,
  input  logic               LOCKED,
  output logic [FREQ_W-1:0]  FREQ_SEL_OUT,
  output logic [PHASE_W-1:0] PHASE_SEL_OUT,
  output logic [DUTY_W-1:0]  DUTY_SEL_OUT,
  output logic               CLK_EN,
  output logic               BUSY,
  output logic               CFG_ERR,
  output logic               LOCK_FAULT
);

  localparam int CMAXP = max3(DRAIN_CYCLES, SETTLE_CYCLES, LOCK_TIMEOUT);
  localparam int CW    = $clog2(CMAXP + 1);
  localparam logic [CW-1:0] DRAIN_END  = CW'(DRAIN_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_END   = CW'(LOCK_TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   lock_s;
  logic [SEL_W-1:0]       cand;
  sel_t                   cand_s;
  logic                   pulse;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  sel_t          out_q;
  sel_t          tgt_q;
  sel_t          pend_code_q;
  logic          pend_q;
  logic          en_q;
  logic          busy_q;
  logic          err_q;
  logic          fault_q;

  logic          req_v;
  sel_t          req_code;

  sel_sync_debounce #(
    .W        (SEL_W),
    .STAGES   (SYNC_STAGES),
    .DEBOUNCE (DEBOUNCE_CYCLES)
  ) u_sel (
    .clk_i   (USER_CLOCK),
    .rst_i   (RESET),
    .raw_i   ({FREQ_SEL_IN, PHASE_SEL_IN, DUTY_SEL_IN}),
    .code_o  (cand),
    .pulse_o (pulse)
  );

  always_ff @(posedge USER_CLOCK) begin
    if (RESET)
      lock_sync_q <= '0;
    else
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], LOCKED};
  end

  assign lock_s   = lock_sync_q[SYNC_STAGES-1];
  assign cand_s   = sel_t'(cand);
  assign req_v    = pulse | pend_q;
  assign req_code = pulse ? cand_s : pend_code_q;

  always_ff @(posedge USER_CLOCK) begin
    if (RESET) begin
      state_q     <= ST_WAIT_LOCK;
      cnt_q       <= '0;
      out_q       <= SEL_RST;
      tgt_q       <= SEL_RST;
      pend_code_q <= SEL_RST;
      pend_q      <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b1;
      err_q       <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      // newest stable code always overwrites the single pending slot
      if (pulse) begin
        pend_q      <= 1'b1;
        pend_code_q <= cand_s;
      end
      unique case (state_q)
        ST_RUN: begin
          if (!lock_s) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b1;
          end else if (req_v) begin
            pend_q <= 1'b0;
            if (req_code != out_q) begin
              if (int'(req_code.freq) >= NUM_FREQ) begin
                err_q <= 1'b1;
              end else begin
                tgt_q   <= req_code;
                state_q <= ST_GATE;
                cnt_q   <= '0;
                en_q    <= 1'b0;
                busy_q  <= 1'b1;
              end
            end
          end
        end
        ST_GATE: begin
          if (cnt_q == DRAIN_END) begin
            state_q <= ST_APPLY;
            out_q   <= tgt_q;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_APPLY: begin
          state_q <= ST_WAIT_LOCK;
          cnt_q   <= '0;
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_q <= ST_SETTLE;
            cnt_q   <= '0;
          end else if (cnt_q == LOCK_END) begin
            state_q <= ST_FAULT;
            fault_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_SETTLE: begin
          if (!lock_s) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == SETTLE_END) begin
            state_q <= ST_RUN;
            en_q    <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_FAULT: begin
          en_q   <= 1'b0;
          busy_q <= 1'b1;
        end
        default: begin
          state_q <= ST_FAULT;
          en_q    <= 1'b0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign FREQ_SEL_OUT  = out_q.freq;
  assign PHASE_SEL_OUT = out_q.phase;
  assign DUTY_SEL_OUT  = out_q.duty;
  assign CLK_EN        = en_q;
  assign BUSY          = busy_q;
  assign CFG_ERR       = err_q;
  assign LOCK_FAULT    = fault_q;

endmodule

// File: tb/tb_mod_clk_cfg_sequencer.sv
// Directed + randomized bench for mod_clk_cfg_sequencer.
// Expected latencies come from the sequencing rules as plain arithmetic.
module tb_mod_clk_cfg_sequencer;

  localparam int SS  = 2;
  localparam int DEB = 32;
  localparam int DRN = 8;
  localparam int SET = 16;
  localparam int LTO = 200;
  localparam int NF  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] f_in;
  logic [4:0] p_in;
  logic [3:0] d_in;
  logic       lk;
  logic [2:0] f_o;
  logic [4:0] p_o;
  logic [3:0] d_o;
  logic       en, busy, err, flt;

  int vec  = 0;
  int miss = 0;

  logic [2:0] ef;
  logic [4:0] ep;
  logic [3:0] ed;
  logic       eerr;

  always #5 clk = ~clk;

  mod_clk_cfg_sequencer #(
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DEB),
    .DRAIN_CYCLES    (DRN),
    .SETTLE_CYCLES   (SET),
    .LOCK_TIMEOUT    (LTO),
    .NUM_FREQ        (NF)
  ) dut (
    .USER_CLOCK    (clk),
    .RESET         (rst),
    .FREQ_SEL_IN   (f_in),
    .PHASE_SEL_IN  (p_in),
    .DUTY_SEL_IN   (d_in),
    .LOCKED        (lk),
    .FREQ_SEL_OUT  (f_o),
    .PHASE_SEL_OUT (p_o),
    .DUTY_SEL_OUT  (d_o),
    .CLK_EN        (en),
    .BUSY          (busy),
    .CFG_ERR       (err),
    .LOCK_FAULT    (flt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input int obs, input int exp);
    vec++;
    assert (obs >= exp - 1 && obs <= exp + 1) else begin
      miss++;
      $error("FAIL %s: got %0d cycles want %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_en(input logic v, input int lim, output int n);
    n = 0;
    while (en !== v && n <= lim) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_cfg(input logic [11:0] c, input int lim, output int n);
    n = 0;
    while ({f_o, p_o, d_o} !== c && n <= lim) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_cfg(input string tag);
    chk(tag, {20'd0, f_o, p_o, d_o}, {20'd0, ef, ep, ed});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_en"}, en, 0);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_cfg"}, {f_o, p_o, d_o}, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_flt"}, flt, 0);
  endtask

  task automatic rand_code(output logic [2:0] f, output logic [4:0] p,
                           output logic [3:0] d);
    f = 3'($urandom_range(0, NF - 1));
    p = 5'($urandom);
    d = 4'($urandom);
    if ({f, p, d} == {ef, ep, ed})
      p = p ^ 5'd1;
  endtask

  // full accepted change with LOCKED held high
  task automatic run_change(input string tag, input logic [2:0] f,
                            input logic [4:0] p, input logic [3:0] d);
    int n;
    f_in = f;
    p_in = p;
    d_in = d;
    wait_en(0, 300, n);
    chk_near({tag, "_fall"}, n, SS + DEB + 1);
    chk({tag, "_busy1"}, busy, 1);
    wait_cfg({f, p, d}, 100, n);
    chk_near({tag, "_apply"}, n, DRN);
    ef = f;
    ep = p;
    ed = d;
    wait_en(1, 300, n);
    chk_near({tag, "_rise"}, n, SET + 2);
    chk_cfg({tag, "_cfg"});
    chk({tag, "_busy0"}, busy, 0);
    chk({tag, "_err"}, err, eerr);
    idle(DEB + 8);
  endtask

  initial begin
    int n;
    logic drop;
    logic [2:0] nf;
    logic [4:0] np;
    logic [3:0] nd;
    logic [2:0] other;

    rst  = 1'b1;
    lk   = 1'b1;
    f_in = '0;
    p_in = '0;
    d_in = '0;
    ef   = '0;
    ep   = '0;
    ed   = '0;
    eerr = 1'b0;
    idle(3);
    chk_reset("rst0");
    rst = 1'b0;
    wait_en(1, 300, n);
    chk_near("boot_rise", n, SS + SET + 1);
    chk_cfg("boot_cfg");
    chk("boot_busy", busy, 0);
    idle(DEB + 4);

    run_change("f02", 3'd2, 5'd0, 4'd0);

    for (int i = 0; i < 6; i++) begin
      rand_code(nf, np, nd);
      run_change($sformatf("rnd%0d", i), nf, np, nd);
    end

    // bouncing input shorter than the debounce window
    other = (ef == 3'd0) ? 3'd1 : 3'd0;
    drop  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      f_in = (i % 2 == 0) ? other : ef;
      for (int k = 0; k < DEB - 12; k++) begin
        tick();
        if (en !== 1'b1) drop = 1'b1;
      end
    end
    for (int k = 0; k < DEB + 10; k++) begin
      tick();
      if (en !== 1'b1) drop = 1'b1;
    end
    chk("bounce_drop", drop, 0);
    chk_cfg("bounce_cfg");

    // illegal frequency code
    f_in = 3'd5;
    drop = 1'b0;
    for (int k = 0; k < SS + DEB + 20; k++) begin
      tick();
      if (en !== 1'b1) drop = 1'b1;
    end
    eerr = 1'b1;
    chk("ill_err", err, 1);
    chk("ill_drop", drop, 0);
    chk_cfg("ill_cfg");
    nf = (ef == 3'd1) ? 3'd2 : 3'd1;
    run_change("after_ill", nf, ep, ed);

    // lock loss while running
    lk = 1'b0;
    wait_en(0, 30, n);
    chk_near("runlk_fall", n, SS + 1);
    chk("runlk_busy", busy, 1);
    chk_cfg("runlk_cfg");
    lk = 1'b1;
    wait_en(1, 300, n);
    chk_near("runlk_rise", n, SS + SET + 1);
    idle(DEB);

    // lock glitch during settle restarts the full settle
    rand_code(nf, np, nd);
    f_in = nf;
    p_in = np;
    d_in = nd;
    wait_en(0, 300, n);
    chk_near("sg_fall", n, SS + DEB + 1);
    wait_cfg({nf, np, nd}, 100, n);
    chk_near("sg_apply", n, DRN);
    ef = nf;
    ep = np;
    ed = nd;
    idle(6);
    lk = 1'b0;
    idle(3);
    lk = 1'b1;
    chk("sg_en_low", en, 0);
    wait_en(1, 300, n);
    chk_near("sg_rise", n, SS + SET + 1);
    chk_cfg("sg_cfg");
    idle(DEB);

    // reset while gating
    rand_code(nf, np, nd);
    f_in = nf;
    p_in = np;
    d_in = nd;
    wait_en(0, 300, n);
    chk_near("rg_fall", n, SS + DEB + 1);
    idle(2);
    rst = 1'b1;
    tick();
    chk_reset("rg");
    ef   = '0;
    ep   = '0;
    ed   = '0;
    eerr = 1'b0;
    idle(2);
    rst = 1'b0;
    wait_en(1, 300, n);
    chk_near("rg_boot", n, SS + SET + 1);
    chk_cfg("rg_bootcfg");
    wait_en(0, 300, n);
    chk_near("rg_pend_fall", n, DEB - SET);
    wait_cfg({nf, np, nd}, 100, n);
    chk_near("rg_apply", n, DRN);
    ef = nf;
    ep = np;
    ed = nd;
    wait_en(1, 300, n);
    chk_near("rg_rise", n, SET + 2);
    idle(DEB);

    // lock never returns after apply
    rand_code(nf, np, nd);
    f_in = nf;
    p_in = np;
    d_in = nd;
    wait_en(0, 300, n);
    chk_near("lt_fall", n, SS + DEB + 1);
    lk = 1'b0;
    wait_cfg({nf, np, nd}, 100, n);
    chk_near("lt_apply", n, DRN);
    n = 0;
    while (flt !== 1'b1 && n <= LTO + 20) begin
      tick();
      n++;
    end
    chk_near("lt_fault", n, LTO + 1);
    chk("lt_en", en, 0);
    chk("lt_busy", busy, 1);
    lk = 1'b1;
    idle(60);
    chk("lt_en_hold", en, 0);
    chk("lt_flt_hold", flt, 1);
    rst = 1'b1;
    tick();
    chk_reset("lt_rst");
    rst = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
